md5_crack_ctrl: RTL and testbench

MD5_CRACK_CTRL -- requirements
Module: md5_crack_ctrl

---
 rtl/md5_crack_pkg.sv | 18 +
 rtl/md5_cand_gen.sv | 54 +++++
 rtl/md5_crack_ctrl.sv | 133 +++++++++++++
 tb/tb_md5_crack_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_crack_pkg.sv
// Shared types and defaults for the MD5 brute-force search controller.
package md5_crack_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam int unsigned DEF_PIPE_LAT     = 66;
  localparam logic [7:0]  DEF_FIRST_CHAR   = 8'h61;
  localparam int unsigned DEF_CHARSET_SIZE = 26;
  localparam int unsigned MAX_CHARS        = 8;

  // Length 0 behaves as 1; anything beyond the candidate register width saturates.
  function automatic logic [3:0] clamp_len(input logic [3:0] n);
    if (n == 4'd0) return 4'd1;
    if (n > 4'(MAX_CHARS)) return 4'(MAX_CHARS);
    return n;
  endfunction

endpackage

// File: rtl/md5_cand_gen.sv
// Digit odometer producing right-justified candidate strings and a last-candidate flag.
module md5_cand_gen
  import md5_crack_pkg::*;
#(
  parameter logic [7:0]  FIRST_CHAR   = DEF_FIRST_CHAR,
  parameter int unsigned CHARSET_SIZE = DEF_CHARSET_SIZE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        step,
  input  logic [3:0]  len,
  output logic [63:0] cand_msg,
  output logic        last
);

  localparam logic [7:0] MaxDigit = 8'(CHARSET_SIZE - 1);

  // Index 0 is the rightmost (fastest-moving) digit.
  logic [MAX_CHARS-1:0][7:0] digit_q, digit_d;
  logic                      carry;

  always_comb begin
    digit_d  = digit_q;
    cand_msg = '0;
    last     = 1'b1;
    carry    = 1'b1;
    for (int k = 0; k < int'(MAX_CHARS); k++) begin
      if (k < int'(len)) begin
        cand_msg[8*k +: 8] = FIRST_CHAR + digit_q[k];
        if (digit_q[k] != MaxDigit) last = 1'b0;
        if (carry) begin
          if (digit_q[k] == MaxDigit) begin
            digit_d[k] = '0;
          end else begin
            digit_d[k] = digit_q[k] + 8'd1;
            carry      = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else if (clear) begin
      digit_q <= '0;
    end else if (step) begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/md5_crack_ctrl.sv
// Search controller: issues candidates to a pipelined MD5 core and watches for the target hash.
module md5_crack_ctrl
  import md5_crack_pkg::*;
#(
  parameter int unsigned PIPE_LAT     = DEF_PIPE_LAT,
  parameter logic [7:0]  FIRST_CHAR   = DEF_FIRST_CHAR,
  parameter int unsigned CHARSET_SIZE = DEF_CHARSET_SIZE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] target,
  input  logic [3:0]   len_chars,
  output logic [63:0]  core_message,
  output logic [63:0]  core_length,
  input  logic [127:0] core_hash,
  input  logic [511:0] core_message_out,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [63:0]  found_msg
);

  state_e              state_q, state_d;
  logic [3:0]          len_q, len_d;
  logic [127:0]        target_q, target_d;
  logic [PIPE_LAT-1:0] vpipe_q, vpipe_d;
  logic                found_q, found_d;
  logic [63:0]         found_msg_q, found_msg_d;
  logic [63:0]         msg_hold_q, len_hold_q;
  logic                issue, clear, last, match;
  logic [63:0]         cand_msg, cand_len, match_msg;
  logic [6:0]          shamt;
  logic                unused_block;

  md5_cand_gen #(
    .FIRST_CHAR   (FIRST_CHAR),
    .CHARSET_SIZE (CHARSET_SIZE)
  ) u_cand_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .step     (issue),
    .len      (len_q),
    .cand_msg (cand_msg),
    .last     (last)
  );

  assign cand_len     = {57'd0, len_q, 3'b000};
  // The padded block carries the message left-justified; shift it back to the right.
  assign shamt        = 7'd64 - {len_q, 3'b000};
  assign match_msg    = core_message_out[511:448] >> shamt;
  assign match        = vpipe_q[PIPE_LAT-1] && (core_hash == target_q);
  assign unused_block = ^core_message_out[447:0];

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    target_d    = target_q;
    found_d     = found_q;
    found_msg_d = found_msg_q;
    vpipe_d     = vpipe_q << 1;
    issue       = 1'b0;
    clear       = 1'b0;
    if (abort) begin
      state_d = StIdle;
      vpipe_d = '0;
      found_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d  = StRun;
            len_d    = clamp_len(len_chars);
            target_d = target;
            clear    = 1'b1;
            found_d  = 1'b0;
            vpipe_d  = '0;
          end
        end
        StRun, StDrain: begin
          if (match) begin
            state_d     = StDone;
            found_d     = 1'b1;
            found_msg_d = match_msg;
          end else if (state_q == StRun) begin
            issue      = 1'b1;
            vpipe_d[0] = 1'b1;
            if (last) state_d = StDrain;
          end else if (vpipe_d == '0) begin
            state_d = StDone;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      target_q    <= '0;
      vpipe_q     <= '0;
      found_q     <= 1'b0;
      found_msg_q <= '0;
      msg_hold_q  <= '0;
      len_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      target_q    <= target_d;
      vpipe_q     <= vpipe_d;
      found_q     <= found_d;
      found_msg_q <= found_msg_d;
      if (issue) begin
        msg_hold_q <= cand_msg;
        len_hold_q <= cand_len;
      end
    end
  end

  always_comb begin
    core_message = (state_q == StRun) ? cand_msg : msg_hold_q;
    core_length  = (state_q == StRun) ? cand_len : len_hold_q;
    busy         = (state_q == StRun) || (state_q == StDrain);
    done         = (state_q == StDone);
    found        = found_q;
    found_msg    = found_msg_q;
  end

endmodule

// File: tb/tb_md5_crack_ctrl.sv
// Scoreboard bench for md5_crack_ctrl with a fixed-latency lookup model of the MD5 core.
module tb_md5_crack_ctrl;

  localparam int unsigned P = 66;
  localparam logic [127:0] HASH_A   = 128'h0cc175b9c0f1b6a831c399e269772661;
  localparam logic [127:0] HASH_ABC = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam logic [127:0] HASH_Z   = 128'hfbade9e36a3f36d3d676c1b808451dd7;

  typedef struct {
    logic        found;
    logic [63:0] msg;
    int          lat;
    int          id;
  } exp_t;

  logic         clk, rst_n, start, abort;
  logic [127:0] target, core_hash;
  logic [3:0]   len_chars;
  logic [63:0]  core_message, core_length, found_msg;
  logic [511:0] core_message_out;
  logic         busy, done, found;

  int   checks, errors, cyc, start_cyc;
  exp_t exp_q[$];

  logic [63:0] mpipe [P];
  logic [63:0] lpipe [P];

  md5_crack_ctrl #(
    .PIPE_LAT     (P),
    .FIRST_CHAR   (8'h61),
    .CHARSET_SIZE (26)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .target           (target),
    .len_chars        (len_chars),
    .core_message     (core_message),
    .core_length      (core_length),
    .core_hash        (core_hash),
    .core_message_out (core_message_out),
    .busy             (busy),
    .done             (done),
    .found            (found),
    .found_msg        (found_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core stand-in: known strings map to real MD5 digests, everything else to a non-matching tag.
  function automatic logic [127:0] model_hash(input logic [63:0] m, input logic [63:0] lb);
    if (lb == 64'd8 && m == 64'h61) return HASH_A;
    if (lb == 64'd8 && m == 64'h7a) return HASH_Z;
    if (lb == 64'd24 && m == 64'h616263) return HASH_ABC;
    return {8'ha5, 56'd0, m};
  endfunction

  function automatic logic [511:0] model_block(input logic [63:0] m, input logic [63:0] lb);
    logic [511:0] b;
    int           n;
    n          = int'(lb[6:0]);
    b          = '0;
    b[511:448] = (n == 0) ? 64'd0 : (m << (64 - n));
    b          = b | (512'h80 << (504 - n));
    b[63:0]    = lb;
    return b;
  endfunction

  always @(posedge clk) begin
    mpipe[0] <= core_message;
    lpipe[0] <= core_length;
    for (int k = 1; k < int'(P); k++) begin
      mpipe[k] <= mpipe[k-1];
      lpipe[k] <= lpipe[k-1];
    end
  end

  assign core_hash        = model_hash(mpipe[P-1], lpipe[P-1]);
  assign core_message_out = model_block(mpipe[P-1], lpipe[P-1]);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_result(input logic f, input logic [63:0] m, input int lat, input int id);
    exp_t e;
    e.found = f;
    e.msg   = m;
    e.lat   = lat;
    e.id    = id;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [3:0] l, input logic [127:0] t);
    @(negedge clk);
    len_chars = l;
    target    = t;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start     = 1'b0;
  endtask

  task automatic wait_result(input int id);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL case%0d_timeout: got no done expected done within 400 cycles", id);
      exp_q.delete();
    end
  endtask

  // Monitor: every rising edge of done consumes one expected result.
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && done && !done_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("case%0d_found", e.id), 128'(found), 128'(e.found));
          check($sformatf("case%0d_latency", e.id), 128'(cyc - start_cyc), 128'(e.lat));
          if (e.found) check($sformatf("case%0d_msg", e.id), 128'(found_msg), 128'(e.msg));
        end
      end
      done_prev = done;
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    start_cyc = 0;
    start     = 1'b0;
    abort     = 1'b0;
    target    = '0;
    len_chars = 4'd1;
    rst_n     = 1'b0;
    #17;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_found", 128'(found), 128'(0));
    check("rst_found_msg", 128'(found_msg), 128'(0));
    check("rst_core_message", 128'(core_message), 128'(0));
    check("rst_core_length", 128'(core_length), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // "a": first candidate matches.
    expect_result(1'b1, 64'h61, 1 + P, 1);
    do_start(4'd1, HASH_A);
    check("case1_busy", 128'(busy), 128'(1));
    check("case1_length", 128'(core_length), 128'(8));
    wait_result(1);

    // Length 0 clamps to 1.
    expect_result(1'b1, 64'h61, 1 + P, 2);
    do_start(4'd0, HASH_A);
    wait_result(2);

    // "abc" is candidate index 28; a stray start mid-run must not disturb it.
    expect_result(1'b1, 64'h616263, 29 + P, 3);
    do_start(4'd3, HASH_ABC);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_result(3);

    // Unreachable target: full sweep, drain, then not-found.
    expect_result(1'b0, 64'h0, 26 + P, 4);
    do_start(4'd1, 128'h0);
    repeat (30) @(posedge clk);
    #1;
    check("case4_drain_busy", 128'(busy), 128'(1));
    check("case4_drain_hold_msg", 128'(core_message), 128'(64'h7a));
    check("case4_drain_done", 128'(done), 128'(0));
    wait_result(4);

    // "z" is the last candidate: match wins over the drain's not-found.
    expect_result(1'b1, 64'h7a, 26 + P, 5);
    do_start(4'd1, HASH_Z);
    wait_result(5);
    repeat (3) @(negedge clk);
    check("case5_done_held", 128'(done), 128'(1));
    check("case5_found_held", 128'(found), 128'(1));

    // Length 15 clamps to 8; then abort mid-run.
    do_start(4'd15, 128'h0);
    check("case6_length", 128'(core_length), 128'(64));
    check("case6_msg0", 128'(core_message), 128'(64'h6161616161616161));
    @(posedge clk);
    #1;
    check("case6_msg1", 128'(core_message), 128'(64'h6161616161616162));
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("case6_abort_busy", 128'(busy), 128'(0));
    check("case6_abort_done", 128'(done), 128'(0));
    check("case6_abort_found", 128'(found), 128'(0));
    expect_result(1'b1, 64'h61, 1 + P, 7);
    do_start(4'd1, HASH_A);
    wait_result(7);

    // Reset mid-run, then a fresh search.
    do_start(4'd1, 128'h0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("case8_rst_busy", 128'(busy), 128'(0));
    check("case8_rst_done", 128'(done), 128'(0));
    check("case8_rst_msg", 128'(core_message), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    expect_result(1'b1, 64'h61, 1 + P, 9);
    do_start(4'd1, HASH_A);
    wait_result(9);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
